// File: rtl/branch_resolve_unit.sv
// Branch condition evaluation and resolution for the ID stage.
// Supplies fetch-stage predictions from a PC-indexed table of 2-bit
// saturating counters, registers the resolved outcome for the flush
// logic one edge later, and keeps saturating branch/mispredict counts.
module branch_resolve_unit #(
  parameter int WORD_LEN  = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] if_pc,
  output logic                pred_taken,
  input  logic                valid_in,
  input  logic                flush,
  input  logic [WORD_LEN-1:0] pc_in,
  input  logic                pred_in,
  input  logic [2:0]          branch_cmd,
  input  logic [WORD_LEN-1:0] rs_value,
  input  logic [WORD_LEN-1:0] rt_value,
  output logic                branch_cond,
  output logic                res_valid,
  output logic                res_taken,
  output logic                mispredict,
  output logic [CNT_W-1:0]    br_count,
  output logic [CNT_W-1:0]    mp_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_JUMP = 3'd1,
    CMD_BEQ  = 3'd2,
    CMD_BNE  = 3'd3,
    CMD_BLTZ = 3'd4,
    CMD_BGEZ = 3'd5,
    CMD_BGTZ = 3'd6,
    CMD_BLEZ = 3'd7
  } cmd_e;

  cmd_e             cmd;
  logic             rs_neg;
  logic             rs_zero;
  logic             live;
  logic             bht_upd;
  logic             mp_ev;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] id_idx;
  logic [1:0]       bht [BHT_DEPTH];
  logic [1:0]       cur_ctr;
  logic [1:0]       nxt_ctr;

  assign cmd     = cmd_e'(branch_cmd);
  assign rs_neg  = rs_value[WORD_LEN-1];
  assign rs_zero = (rs_value == '0);
  assign live    = valid_in & ~flush & (cmd != CMD_NONE);
  assign bht_upd = live & (cmd != CMD_JUMP);
  assign mp_ev   = live & (branch_cond != pred_in);

  // Word-aligned PCs: bits above the index are ignored, so entries alias.
  assign if_idx     = if_pc[IDX_W+1:2];
  assign id_idx     = pc_in[IDX_W+1:2];
  assign pred_taken = bht[if_idx][1];
  assign cur_ctr    = bht[id_idx];

  // Branch condition for the ID instruction, independent of valid/flush
  always_comb begin
    branch_cond = 1'b0;
    unique case (cmd)
      CMD_NONE: branch_cond = 1'b0;
      CMD_JUMP: branch_cond = 1'b1;
      CMD_BEQ:  branch_cond = (rs_value == rt_value);
      CMD_BNE:  branch_cond = (rs_value != rt_value);
      CMD_BLTZ: branch_cond = rs_neg;
      CMD_BGEZ: branch_cond = ~rs_neg;
      CMD_BGTZ: branch_cond = ~rs_neg & ~rs_zero;
      CMD_BLEZ: branch_cond = rs_neg | rs_zero;
      default:  branch_cond = 1'b0;
    endcase
  end

  // Saturating 2-bit counter step toward the resolved outcome
  always_comb begin
    nxt_ctr = cur_ctr;
    if (branch_cond) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
    end
  end

  // Predictor table: reset to weakly not-taken, trained by conditional branches
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < unsigned'(BHT_DEPTH); i++) bht[i] <= 2'b01;
    end else if (bht_upd) begin
      bht[id_idx] <= nxt_ctr;
    end
  end

  // Registered resolution result and saturating statistics
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      mispredict <= 1'b0;
      br_count   <= '0;
      mp_count   <= '0;
    end else begin
      res_valid  <= live;
      res_taken  <= live & branch_cond;
      mispredict <= mp_ev;
      if (live && (br_count != '1)) br_count <= br_count + 1'b1;
      if (mp_ev && (mp_count != '1)) mp_count <= mp_count + 1'b1;
    end
  end

endmodule
